fifo_rd_drain_ctrl: RTL

Read-side controller that drains the 2-clock FIFO envelope built on the compiled 1r1w RAM. It generates rd_op from the FIFO's rd_empty flag and the RAM's fixed read latency, and captures returning rd_data into a small skid buffer. It presents the words downstream as a valid/ready stream with full backpressure, a drain enable and a flush sequence. It sits entirely in the rd_clk domain, between the envelope's read port and the consuming datapath.

---
 rtl/fifo_rd_drain_ctrl_pkg.sv | 25 ++
 rtl/fifo_rd_skid_buf.sv | 60 ++++++
 rtl/fifo_rd_drain_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/fifo_rd_drain_ctrl_pkg.sv
// Shared definitions for the FIFO read-drain controller: FSM encoding and
// elaboration-time parameter legality helpers.
package fifo_rd_drain_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN        = 2'd1,
    FLUSH_WAIT = 2'd2,
    FLUSH_DROP = 2'd3
  } state_t;

  localparam int RD_LAT_MIN  = 1;
  localparam int RD_LAT_MAX  = 2;
  // The skid buffer must absorb every read already in flight plus the head word.
  localparam int SKID_MARGIN = 1;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

  function automatic bit skid_depth_ok(input int depth, input int lat);
    return depth >= (lat + SKID_MARGIN);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular register-array skid buffer with wrap-around pointers, occupancy
// count and a one-cycle clear; head word is read combinationally.
module fifo_rd_skid_buf
#(
  parameter int DAT_WIDTH  = 32,
  parameter int SKID_DEPTH = 3,
  parameter int OCC_W      = $clog2(SKID_DEPTH + 1)
) (
  input  logic                 rd_clk,
  input  logic                 rd_reset,
  input  logic                 push,
  input  logic [DAT_WIDTH-1:0] push_data,
  input  logic                 pop,
  input  logic                 clear,
  output logic [OCC_W-1:0]     occ,
  output logic [DAT_WIDTH-1:0] head
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SKID_DEPTH - 1);

  logic [DAT_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [OCC_W-1:0]     occ_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge rd_clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + OCC_W'(1);
        2'b01:   occ_reg <= occ_reg - OCC_W'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  assign occ  = occ_reg;
  assign head = mem[rd_ptr_reg];

endmodule

// File: rtl/fifo_rd_drain_ctrl.sv
// Read-side drain controller: credit-limited rd_op issue, in-flight tracking
// for the RAM read latency, skid capture, valid/ready output and flush FSM.
module fifo_rd_drain_ctrl
  import fifo_rd_drain_ctrl_pkg::*;
#(
  parameter int DAT_WIDTH  = 32,
  parameter int RD_LAT     = 1,
  parameter int SKID_DEPTH = RD_LAT + 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_reset,
  input  logic                 enable,
  input  logic                 flush_req,
  output logic                 flush_done,
  input  logic                 rd_empty,
  output logic                 rd_op,
  input  logic [DAT_WIDTH-1:0] rd_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DAT_WIDTH-1:0] out_data,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_cnt
);

  localparam int SKID_OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int OCC_W      = $clog2(SKID_DEPTH + RD_LAT + 1);

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("fifo_rd_drain_ctrl: RD_LAT must be 1 or 2");
  end
  if (!skid_depth_ok(SKID_DEPTH, RD_LAT)) begin : g_bad_skid_depth
    $error("fifo_rd_drain_ctrl: SKID_DEPTH must be at least RD_LAT+1");
  end

  state_t                state_reg;
  logic [RD_LAT-1:0]     inflight_reg;
  logic [CNT_WIDTH-1:0]  word_cnt_reg;
  logic [SKID_OCC_W-1:0] skid_occ;
  logic [DAT_WIDTH-1:0]  skid_head;
  logic [OCC_W-1:0]      inflight_cnt;
  logic [OCC_W-1:0]      occ;
  logic                  credit;
  logic                  land;
  logic                  pop;
  logic                  clear;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight_cnt = inflight_cnt + OCC_W'(inflight_reg[i]);
    end
  end

  assign occ    = OCC_W'(skid_occ) + inflight_cnt;
  assign credit = occ < OCC_W'(SKID_DEPTH);
  // A flush request wins in its own cycle so nothing new is pulled once it arrives.
  assign rd_op  = (state_reg == RUN) & ~flush_req & ~rd_empty & credit;
  assign land   = inflight_reg[RD_LAT-1];
  assign clear  = (state_reg == FLUSH_DROP);

  assign out_valid  = (skid_occ != '0);
  assign out_data   = out_valid ? skid_head : '0;
  assign pop        = out_valid & out_ready;
  assign busy       = (occ != '0);
  assign flush_done = clear;
  assign word_cnt   = word_cnt_reg;

  always_ff @(posedge rd_clk or posedge rd_reset) begin
    if (rd_reset) begin
      state_reg    <= IDLE;
      inflight_reg <= '0;
      word_cnt_reg <= '0;
    end else begin
      inflight_reg <= (inflight_reg << 1) | RD_LAT'(rd_op);
      if (pop && (word_cnt_reg != '1)) begin
        word_cnt_reg <= word_cnt_reg + CNT_WIDTH'(1);
      end
      case (state_reg)
        IDLE: begin
          if (flush_req)   state_reg <= FLUSH_WAIT;
          else if (enable) state_reg <= RUN;
        end
        RUN: begin
          if (flush_req)    state_reg <= FLUSH_WAIT;
          else if (!enable) state_reg <= IDLE;
        end
        FLUSH_WAIT: begin
          if (inflight_cnt == '0) state_reg <= FLUSH_DROP;
        end
        FLUSH_DROP: begin
          state_reg <= enable ? RUN : IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  fifo_rd_skid_buf #(
    .DAT_WIDTH  (DAT_WIDTH),
    .SKID_DEPTH (SKID_DEPTH),
    .OCC_W      (SKID_OCC_W)
  ) u_skid (
    .rd_clk    (rd_clk),
    .rd_reset  (rd_reset),
    .push      (land),
    .push_data (rd_data),
    .pop       (pop),
    .clear     (clear),
    .occ       (skid_occ),
    .head      (skid_head)
  );

endmodule
